inst_prefetch_queue: RTL

Instruction prefetch unit for the pipelined MIPS core. It sits between a handshaked, variable-latency instruction memory and the IF/ID pipeline register, and replaces the bare PC-to-memory fetch path. It fetches sequential words ahead of decode into a small FIFO. Branch and jump redirects from ID flush it, and any in-flight fetch response is discarded.

---
 rtl/inst_prefetch_queue.sv | 119 +++++++++++
 1 files changed

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - sequential instruction prefetch FIFO with redirect flush
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       memReq,
    output logic [31:0]                memAddr,
    input  logic                       memAck,
    input  logic [31:0]                memData,
    input  logic                       redirect,
    input  logic [31:0]                redirectAdr,
    input  logic                       deqReady,
    output logic                       instValid,
    output logic [31:0]                instOut,
    output logic [31:0]                instPcPlus4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state;
    logic [31:0]   fetchPc;
    logic [31:0]   reqAddr;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [31:0]   instMem [DEPTH];
    logic [31:0]   pcMem   [DEPTH];

    logic          ack;
    logic          push;
    logic          pop;
    logic [31:0]   target;
    logic [31:0]   reqNext;
    logic [CW-1:0] countNext;

    assign memReq    = (state == REQ) || (state == DROP);
    assign memAddr   = reqAddr;
    assign ack       = memAck && memReq;
    assign target    = {redirectAdr[31:2], 2'b00};
    assign reqNext   = reqAddr + 32'd4;
    // Responses are only queued in REQ; an ack in DROP belongs to an abandoned request.
    assign push      = (state == REQ) && ack && !redirect;
    assign pop       = instValid && deqReady && !redirect;
    assign countNext = count + CW'(push) - CW'(pop);

    assign instValid   = (count != '0);
    assign instOut     = instValid ? instMem[rdPtr] : 32'h0;
    assign instPcPlus4 = instValid ? pcMem[rdPtr]   : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            reqAddr <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            if (redirect) begin
                rdPtr   <= '0;
                wrPtr   <= '0;
                count   <= '0;
                fetchPc <= target;
            end else begin
                if (push) wrPtr <= wrPtr + PW'(1);
                if (pop)  rdPtr <= rdPtr + PW'(1);
                count <= countNext;
            end

            case (state)
                IDLE: begin
                    if (redirect) begin
                        state   <= REQ;
                        reqAddr <= target;
                    end else if (count < FULL) begin
                        state   <= REQ;
                        reqAddr <= fetchPc;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        if (ack) reqAddr <= target;
                        else     state   <= DROP;
                    end else if (ack) begin
                        fetchPc <= reqNext;
                        // Only issue the next word if its slot is guaranteed at ack time.
                        if (countNext < FULL) reqAddr <= reqNext;
                        else                  state   <= IDLE;
                    end
                end
                DROP: begin
                    if (ack) begin
                        state   <= REQ;
                        reqAddr <= redirect ? target : fetchPc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instMem[wrPtr] <= memData;
            pcMem[wrPtr]   <= reqNext;
        end
    end

    always @(posedge clk) begin
        if (rst && push && !pop) assert (count != FULL);
    end

endmodule
